// File: rtl/alu_pkg.sv
// Shared command codes and controller state encoding for the bit-serial ALU.
package alu_pkg;

    localparam logic [1:0] CMD_NOT_B = 2'b00;
    localparam logic [1:0] CMD_OR    = 2'b01;
    localparam logic [1:0] CMD_AND   = 2'b10;
    localparam logic [1:0] CMD_SUM   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice with carry-in; carry-out is only meaningful for SUM.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_cin,
    input  logic [1:0] i_command,
    output logic       o_res,
    output logic       o_cout
);

    always_comb begin
        o_res  = 1'b0;
        o_cout = 1'b0;
        case (i_command)
            CMD_NOT_B: o_res = ~i_b;
            CMD_OR:    o_res = i_a | i_b;
            CMD_AND:   o_res = i_a & i_b;
            CMD_SUM: begin
                o_res  = i_a ^ i_b ^ i_cin;
                o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
            end
            default: begin
                o_res  = 1'b0;
                o_cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: WIDTH-bit ops through one slice, LSB first, with START/BUSY/DONE.
// Optional ZERO result flag enabled by defining SERIAL_ALU_CTRL_ZERO_FLAG_EN.
//
// state   | meaning
// IDLE    | waiting for START
// RUN     | one result bit per clock, WIDTH clocks
// FIN     | one-cycle DONE; RESULT/CARRY_OUT valid, START accepted back-to-back
module serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_command,
    input  logic [WIDTH-1:0] i_a_in,
    input  logic [WIDTH-1:0] i_b_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out
`ifdef SERIAL_ALU_CTRL_ZERO_FLAG_EN
    ,
    output logic             o_zero
`endif
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_cmd;
    logic             r_carry;
    logic             r_carry_out;
    logic [CNT_W-1:0] r_cnt;

    logic             w_res_bit;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;
    logic             w_is_sum;
    logic [WIDTH-1:0] w_result_nxt;

    assign w_accept     = i_start && ((r_state == ST_IDLE) || (r_state == ST_FIN));
    assign w_last       = (r_state == ST_RUN) && (r_cnt == LAST_BIT);
    assign w_is_sum     = (r_cmd == CMD_SUM);
    assign w_result_nxt = {w_res_bit, r_result[WIDTH-1:1]};

    alu_bit_slice u_slice (
        .i_a       (r_a_sh[0]),
        .i_b       (r_b_sh[0]),
        .i_cin     (r_carry),
        .i_command (r_cmd),
        .o_res     (w_res_bit),
        .o_cout    (w_cout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST_BIT) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                w_state_nxt = i_start ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counter saturates at the last bit so it never wraps while leaving RUN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd       <= CMD_NOT_B;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
        end else if (w_accept) begin
            r_cmd   <= i_command;
            r_a_sh  <= i_a_in;
            r_b_sh  <= i_b_in;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_result <= w_result_nxt;
            r_carry  <= w_is_sum ? w_cout : 1'b0;
            if (w_last) begin
                r_carry_out <= w_is_sum ? w_cout : 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_ALU_CTRL_ZERO_FLAG_EN
    logic r_zero;

    // Evaluated on the final RUN edge so the flag is already valid during FIN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_zero <= 1'b0;
        end else if (w_last) begin
            r_zero <= (w_result_nxt == '0);
        end
    end

    assign o_zero = r_zero;
`endif

    assign o_busy      = (r_state == ST_RUN);
    assign o_done      = (r_state == ST_FIN);
    assign o_result    = r_result;
    assign o_carry_out = r_carry_out;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: directed cases plus randomized ops against an arithmetic model.
module tb_serial_alu_ctrl;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       cmd = 2'b00;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
`ifdef SERIAL_ALU_CTRL_ZERO_FLAG_EN
    logic             zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_command   (cmd),
        .i_a_in      (a),
        .i_b_in      (b),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_carry_out (carry)
`ifdef SERIAL_ALU_CTRL_ZERO_FLAG_EN
        ,
        .o_zero      (zero)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Result of an op as a WIDTH+1 bit value: carry in the top bit.
    function automatic logic [WIDTH:0] ref_op(input logic [1:0] c, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
        case (c)
            CMD_NOT_B: ref_op = {1'b0, ~y};
            CMD_OR:    ref_op = {1'b0, x | y};
            CMD_AND:   ref_op = {1'b0, x & y};
            default:   ref_op = {1'b0, x} + {1'b0, y};
        endcase
    endfunction

    // Called just after the edge that accepted START; returns at the negedge where DONE is seen.
    task automatic wait_done(input bit noise, output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (busy) nbusy++;
            lat++;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                cmd   = 2'($urandom);
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
            end
            if (lat > WIDTH + 8) begin
                check_eq("timeout", 64'(lat), 64'(WIDTH));
                break;
            end
        end
    endtask

    task automatic run_op(input logic [1:0] c, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input bit noise, input string tag);
        logic [WIDTH:0] expv;
        int lat;
        int nb;
        expv = ref_op(c, x, y);
        @(negedge clk);
        cmd   = c;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cmd   = 2'($urandom);
        wait_done(noise, lat, nb);
        start = 1'b0;
        check_eq({tag, "_lat"},   64'(lat),    64'(WIDTH));
        check_eq({tag, "_busy"},  64'(nb),     64'(WIDTH));
        check_eq({tag, "_res"},   64'(result), 64'(expv[WIDTH-1:0]));
        check_eq({tag, "_carry"}, 64'(carry),  64'(expv[WIDTH]));
`ifdef SERIAL_ALU_CTRL_ZERO_FLAG_EN
        check_eq({tag, "_zero"},  64'(zero),   64'(expv[WIDTH-1:0] == '0));
`endif
        @(negedge clk);
        check_eq({tag, "_done1"}, 64'(done),   64'(0));
        check_eq({tag, "_hold"},  64'(result), 64'(expv[WIDTH-1:0]));
    endtask

    initial begin
        int lat;
        int nb;
        bit seen;

        #12;
        check_eq("rst_busy",   64'(busy),   64'(0));
        check_eq("rst_done",   64'(done),   64'(0));
        check_eq("rst_result", 64'(result), 64'(0));
        check_eq("rst_carry",  64'(carry),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(CMD_SUM,   8'hFF, 8'h01, 1'b0, "sum_ovf");
        run_op(CMD_NOT_B, 8'hA5, 8'h3C, 1'b0, "not_b");
        run_op(CMD_OR,    8'hA5, 8'h3C, 1'b0, "or");
        run_op(CMD_AND,   8'hA5, 8'h3C, 1'b0, "and");
        run_op(CMD_SUM,   8'h12, 8'h34, 1'b1, "start_in_run");
        run_op(CMD_SUM,   8'h80, 8'h80, 1'b0, "sum_zero");
        run_op(CMD_SUM,   8'h01, 8'h01, 1'b0, "sum_small");

        // Back-to-back: START held through op1, op2 presented during FIN.
        @(negedge clk);
        cmd   = CMD_SUM;
        a     = 8'h80;
        b     = 8'h80;
        start = 1'b1;
        @(posedge clk);
        wait_done(1'b0, lat, nb);
        check_eq("b2b1_res",   64'(result), 64'(8'h00));
        check_eq("b2b1_carry", 64'(carry),  64'(1));
        cmd = CMD_AND;
        a   = 8'hF0;
        b   = 8'h3C;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0, lat, nb);
        check_eq("b2b_gap",    64'(lat + 1), 64'(WIDTH + 1));
        check_eq("b2b2_res",   64'(result),  64'(8'h30));
        check_eq("b2b2_carry", 64'(carry),   64'(0));
        @(negedge clk);

        // Leave nonzero RESULT and CARRY_OUT behind, then reset mid-operation.
        run_op(CMD_SUM, 8'hFF, 8'h02, 1'b0, "pre_rst");
        @(negedge clk);
        cmd   = CMD_SUM;
        a     = 8'h0F;
        b     = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy",   64'(busy),   64'(0));
        check_eq("mid_rst_done",   64'(done),   64'(0));
        check_eq("mid_rst_result", 64'(result), 64'(0));
        check_eq("mid_rst_carry",  64'(carry),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check_eq("post_rst_idle",   64'(seen),   64'(0));
        check_eq("post_rst_result", 64'(result), 64'(0));

        for (int i = 0; i < 25; i++) begin
            logic [1:0]       rc;
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            rc = 2'($urandom);
            ra = WIDTH'($urandom);
            rb = (i % 5 == 0) ? WIDTH'(0) : WIDTH'($urandom);
            run_op(rc, ra, rb, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
